// File: rtl/gate_test_seq_if.sv
// Bundle between the lab top level / inverter bank and the gate self-test
// controller.
// Signals:
//   start    - request to begin a sweep
//   gate_y   - inverter bank outputs
//   gate_a   - registered stimulus to the inverter bank
//   busy     - sweep in progress
//   done     - one-cycle end-of-sweep pulse
//   pass     - result of the last completed sweep
//   err_cnt  - saturating mismatch count
//   fail_vec - first failing vector
// Modports: master = lab top / bank side, slave = controller side.
interface gate_test_seq_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic [WIDTH-1:0] gate_y;
  logic [WIDTH-1:0] gate_a;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] fail_vec;

  modport master (
    output start, gate_y,
    input  gate_a, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start, gate_y,
    output gate_a, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_test_seq.sv
// Self-test sequencer for a bank of WIDTH parallel inverters. Sweeps all
// 2^WIDTH input vectors, waits SETTLE cycles after driving each one, and
// checks the bank output against the bitwise inverse of the stimulus.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - gate_test_seq_if slave modport (start, gate_y in; gate_a, busy,
//         done, pass, err_cnt, fail_vec out; all outputs registered)
// Build option: define GATE_TEST_STOP_ON_ERR_EN to end the sweep at the
// first mismatch and keep the failing vector on gate_a for probing.
module gate_test_seq #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  gate_test_seq_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e           state_q,  state_d;
  // gate_a doubles as the vector counter: the driven vector is always the
  // current sweep index.
  logic [WIDTH-1:0] gate_a_q, gate_a_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             flag_q,   flag_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             pass_q,   pass_d;
  logic [ERR_W-1:0] err_q,    err_d;
  logic [WIDTH-1:0] fvec_q,   fvec_d;
  logic             mismatch_c;

  assign mismatch_c = (bus.gate_y != ~gate_a_q);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gate_a_q <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      gate_a_q <= gate_a_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    gate_a_d = gate_a_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fvec_d   = fvec_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          gate_a_d = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          fvec_d   = '0;
          flag_d   = 1'b0;
          state_d  = S_DRIVE;
        end
      end

      S_DRIVE: begin
        cnt_d   = CNT_W'(SETTLE);
        state_d = (SETTLE == 0) ? S_CHECK : S_SETTLE;
      end

      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mismatch_c) begin
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!flag_q) begin
            fvec_d = gate_a_q;
            flag_d = 1'b1;
          end
        end
`ifdef GATE_TEST_STOP_ON_ERR_EN
        if (mismatch_c || (&gate_a_q)) begin
          state_d = S_DONE;
        end else begin
          gate_a_d = gate_a_q + WIDTH'(1);
          state_d  = S_DRIVE;
        end
`else
        if (&gate_a_q) begin
          state_d = S_DONE;
        end else begin
          gate_a_d = gate_a_q + WIDTH'(1);
          state_d  = S_DRIVE;
        end
`endif
      end

      S_DONE: begin
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // busy/done registered from the next state so they align with it.
    busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  assign bus.gate_a   = gate_a_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fvec_q;

endmodule

// File: doc/gate_test_seq.md
Name: gate_test_seq

Overview:
- Self-test controller that sequences a combinational inverter bank (WIDTH parallel 1-bit inverters).
- Sweeps every input vector, waits a programmable settle time, and checks each output against the expected bitwise inverse.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits between the lab top level (start button / LEDs) and the gate datapath under test.

Parameters:
- WIDTH, 1, number of inverters in the bank; the sweep covers V = 2^WIDTH vectors (legal 1..8).
- SETTLE, 2, idle cycles between driving a vector and sampling the result (legal 0..15).
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a sweep; sampled only in IDLE.
- gate_a  out  WIDTH  registered stimulus driven to the inverter bank inputs.
- gate_y  in  WIDTH  inverter bank outputs.
- busy  out  1  high while a sweep is in progress.
- done  out  1  single-cycle pulse when a sweep ends.
- pass  out  1  result of the last completed sweep.
- err_cnt  out  ERR_W  count of mismatching vectors, saturating.
- fail_vec  out  WIDTH  vector of the first mismatch in the last sweep.

Behaviour:
- Reset (rst high at an edge), in any state including mid-sweep:
  - next state IDLE;
  - gate_a=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0;
  - internal vector counter, settle counter and first-fail flag cleared.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE:
  - On start=1: gate_a<=0, vec<=0, err_cnt<=0, pass<=0, fail_vec<=0, first-fail flag cleared; go to DRIVE.
  - Otherwise hold all outputs.
- DRIVE (1 cycle):
  - Load settle counter with SETTLE.
  - Go to SETTLE, or directly to CHECK if SETTLE=0.
- SETTLE (SETTLE cycles):
  - Decrement the counter.
  - Go to CHECK when the counter reaches 1.
- CHECK (1 cycle), compare gate_y with ~gate_a:
  - On mismatch: err_cnt increments, saturating at 2^ERR_W-1 with no wrap.
  - On the first mismatch of the sweep: fail_vec<=gate_a and the flag is set.
  - If vec = all-ones: go to DONE.
  - Else: vec<=vec+1, gate_a<=vec+1, go to DRIVE.
- DONE (1 cycle):
  - done=1; pass<=(err_cnt==0); go to IDLE.
- busy:
  - 1 in DRIVE, SETTLE and CHECK; 0 in IDLE and DONE.
- Timing:
  - gate_a stays stable from entry to DRIVE through the end of CHECK (SETTLE+2 cycles per vector).
  - gate_y is sampled at the closing edge of CHECK.
  - If start is sampled at edge 0, busy is high in cycles 1..V*(SETTLE+2) and done is high in cycle V*(SETTLE+2)+1.
- Output persistence:
  - pass, err_cnt and fail_vec hold their values after DONE until the next accepted start or reset.
  - gate_a holds the last vector after DONE.
- Boundary cases:
  - start while busy or in DONE is ignored; no restart and no extra done pulse.
  - start held high continuously causes a new sweep on the cycle after each return to IDLE.
  - fail_vec=0 with pass=1 means no failure was recorded.
  - Vector counter wrap is never reached; the sweep terminates at all-ones.

Optional Feature:
- Macro: GATE_TEST_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch in CHECK goes directly to DONE (err_cnt=1, fail_vec=failing vector, pass=0).
  - gate_a keeps driving the failing vector until the next start or reset, for probing.
- Undefined:
  - The full sweep always runs; err_cnt counts all mismatches.

Test Plan:
- WIDTH=1, SETTLE=2, gate_y=~gate_a, start at edge 0 -> gate_a=0 in cycles 1-4 and 1 in cycles 5-8; busy in cycles 1-8; done only in cycle 9; pass=1, err_cnt=0.
- WIDTH=1, SETTLE=2, gate_y stuck at 0 -> done in cycle 9, err_cnt=1, fail_vec=0, pass=0.
- WIDTH=4, SETTLE=2, gate_y=gate_a (buffer fault) -> done in cycle 65, err_cnt=16, fail_vec=0, pass=0.
- WIDTH=1, SETTLE=2, rst at cycle 5 -> from cycle 6 all outputs 0 and no done pulse; a new start gives the clean result of case 1.
- start pulses at cycles 3 and 9 during a run -> exactly one done (cycle 9), no restart, busy low in cycle 10.
- WIDTH=4, SETTLE=2, only vector 5 faulty:
  - With macro: done in cycle 25, err_cnt=1, fail_vec=5, gate_a holds 5.
  - Without macro: done in cycle 65, err_cnt=1, fail_vec=5.
